// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions used by the multiply/divide unit.
// Holds op encodings, the MDU state type and the iteration count.
package mips_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_t;

    localparam int MDU_ITER = 32;

    function automatic logic mdu_op_signed(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic mdu_op_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Multiply: shift-add on {upper, multiplier}. Divide: restoring step on {rem, dividend/quotient}.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, operand_i};

        if (is_div_i) begin
            // A non-negative difference means the divisor fits: keep it and shift in a 1.
            if (!diff[WIDTH+1]) begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {add_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Sign-magnitude: magnitudes iterate for 32 cycles, signs are applied in FIX.
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t         state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    mdu_op_t            op_in;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_in = mdu_op_t'(op);
    assign a_neg = mdu_op_signed(op_in) && a[WIDTH-1];
    assign b_neg = mdu_op_signed(op_in) && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .is_div_i  (is_div_q),
        .acc_o     (acc_step)
    );

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // start wins over a simultaneous move; the move is dropped.
                    is_div_d   = mdu_op_div(op_in);
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = (b == '0);
                    cnt_d      = '0;
                    if (mdu_op_div(op_in)) begin
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
                    state_d = RUN;
                end else begin
                    if (mthi) hi_d = a;
                    if (mtlo) lo_d = a;
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(MDU_ITER - 1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    // Divide by zero yields an all-ones quotient regardless of signs.
                    hi_d = rem_fix;
                    lo_d = div_zero_q ? '1 : quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops
// compared against a plain-arithmetic reference of MULT/MULTU/DIV/DIVU.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         mthi  = 1'b0;
    logic         mtlo  = 1'b0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // MIPS semantics computed with 64-bit integer arithmetic.
    function automatic void model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] rh, output logic [31:0] rl);
        longint          sx, sy, q, r;
        longint unsigned p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rh = '0;
        rl = '0;
        case (o)
            2'b00: begin
                p  = longint'(sx * sy);
                rh = p[63:32];
                rl = p[31:0];
            end
            2'b01: begin
                p  = {32'b0, x} * {32'b0, y};
                rh = p[63:32];
                rl = p[31:0];
            end
            default: begin
                if (y == 0) begin
                    rh = x;
                    rl = '1;
                end else if (o == 2'b10) begin
                    q  = sx / sy;
                    r  = sx % sy;
                    rl = q[31:0];
                    rh = r[31:0];
                end else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit inject, input bit move_with_start, input string tag);
        logic [31:0] eh, el, hi0, lo0;
        int busy_n, done_n, done_at;
        model_op(o, x, y, eh, el);
        hi0 = m_hi;
        lo0 = m_lo;
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        if (move_with_start) begin
            mthi = 1'b1;
            mtlo = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        a     = $urandom;
        b     = $urandom;
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (inject && k == 10) begin
                start = 1'b1;
                op    = o ^ 2'b10;
                mthi  = 1'b1;
                mtlo  = 1'b1;
                a     = $urandom;
            end
            if (inject && k == 11) begin
                start = 1'b0;
                mthi  = 1'b0;
                mtlo  = 1'b0;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = k;
            end
            if (k == 33) begin
                check({tag, " hi_hold"}, hi, hi0);
                check({tag, " lo_hold"}, lo, lo0);
            end
        end
        check({tag, " hi"}, hi, eh);
        check({tag, " lo"}, lo, el);
        check({tag, " busy_cycles"}, busy_n, 33);
        check({tag, " done_pulses"}, done_n, 1);
        check({tag, " done_cycle"}, done_at, 34);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic do_move(input bit hi_en, input bit lo_en, input logic [31:0] val, input string tag);
        @(negedge clk);
        mthi = hi_en;
        mtlo = lo_en;
        a    = val;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        if (hi_en) m_hi = val;
        if (lo_en) m_lo = val;
        @(negedge clk);
        check({tag, " hi"}, hi, m_hi);
        check({tag, " lo"}, lo, m_lo);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;

        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        rst = 1'b1;

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, "mult_neg3x5");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_neg7by2");
        run_op(2'b11, 32'd100, 32'd0, 0, 0, "divu_by0");
        run_op(2'b10, 32'hFFFF_FF00, 32'd0, 0, 0, "div_neg_by0");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");

        do_move(1, 0, 32'h0000_1234, "mthi");
        do_move(0, 1, 32'hCAFE_F00D, "mtlo");
        do_move(1, 1, 32'h5A5A_A5A5, "mthi_mtlo");

        run_op(2'b11, 32'd1000, 32'd7, 1, 0, "ignore_busy");
        run_op(2'b00, 32'd9, 32'hFFFF_FFFE, 0, 1, "start_beats_move");

        // Abort a DIV mid-run with reset.
        @(negedge clk);
        op    = 2'b10;
        a     = 32'd12345;
        b     = 32'd67;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort hi", hi, 0);
        check("abort lo", lo, 0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b1;

        run_op(2'b01, 32'd7, 32'd6, 0, 0, "multu_7x6");

        for (int i = 0; i < 20; i++) begin
            r_op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       r_a = 32'h8000_0000;
                1:       r_a = 32'hFFFF_FFFF;
                default: r_a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       r_b = 32'd0;
                1:       r_b = 32'hFFFF_FFFF;
                2:       r_b = 32'($urandom_range(1, 15));
                default: r_b = $urandom;
            endcase
            run_op(r_op, r_a, r_b, 0, 0, $sformatf("rand%0d_op%0d", i, r_op));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit with HI/LO registers for the multi-cycle MIPS datapath. It sits beside the ALU stage. It takes the latched register operands (A/B latches) and an operation from the controller, and runs one iteration per clock. Its HI/LO values feed the register write-back mux for MFHI/MFLO. The controller stalls its state machine on `busy`.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request to begin an operation; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  operand rs (multiplicand or dividend).
- `b`  in  WIDTH  operand rt (multiplier or divisor).
- `mthi`  in  1  write `a` into HI; honoured only in IDLE.
- `mtlo`  in  1  write `a` into LO; honoured only in IDLE.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `hi`  out  WIDTH  HI register (product upper half, or remainder).
- `lo`  out  WIDTH  LO register (product lower half, or quotient).

## Operation
- States: IDLE, RUN, FIX.
- **IDLE**
  - `start=1` at an edge: capture op, operand magnitudes and result sign flags, clear the iteration counter, go to RUN.
  - Otherwise `mthi`/`mtlo` update HI/LO at that edge. Both may be asserted together.
- **RUN**
  - One iteration per edge; the 6-bit counter runs 0..31.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract; 33-bit partial remainder, quotient shifted in at the LSB.
  - After the 32nd iteration, go to FIX.
- **FIX**
  - Apply the signs:
    - signed MULT: negate the 64-bit product if the operand signs differ.
    - signed DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Write HI/LO, go to IDLE.
- Unsigned ops skip sign handling: the magnitudes are the raw operands.
- Divide by zero (either signedness): HI = `a` as captured, LO = all ones. Still takes the full latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This follows from the magnitude arithmetic with no special case.
- `start`, `mthi`, `mtlo` are ignored while in RUN or FIX.
- Simultaneous `start` and `mthi`/`mtlo` in IDLE: `start` wins; the move is dropped.
- HI/LO keep their old values throughout RUN. Intermediate values live in internal working registers only.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0. Reset asserted mid-operation aborts it immediately, with no partial HI/LO update.
- Edge E0 accepts `start`. `busy` is 1 from after E0 through the cycle before E33.
- Iterations run on edges E1..E32. The FIX write happens at E33.
- After E33: `busy`=0, `done`=1 for exactly one cycle, and `hi`/`lo` hold the result.
- Latency from the start edge to a readable result is 33 cycles.
- A new `start` is accepted at E33+1 at the earliest. Back-to-back operations therefore have a 34-cycle issue period.
- `mthi`/`mtlo` take effect at the sampling edge; the new value is visible on the next cycle.
- `busy` and `done` are registered outputs, not decoded combinationally from the inputs.

## Structure
- Shared package `mips_pkg`:
  - op encodings `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`.
  - state enum `mdu_state_t` (IDLE, RUN, FIX).
  - constant `MDU_ITER = 32`.
- One natural sub-module, `mdu_step`: purely combinational single-iteration datapath.
  - Inputs: accumulator/remainder, operand, mode.
  - Output: the next values.
  - The FSM, counter and HI/LO stay in `mul_div_unit`.

## Test plan
- **Signed multiply:** MULT a=0xFFFFFFFD (−3), b=5 → after 33 cycles `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, `done` pulses once, `busy` high for exactly 33 cycles.
- **Unsigned multiply:** MULTU a=b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **Signed divide:** DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- **Divide edge cases:**
  - DIVU a=100, b=0 → `hi`=0x64, `lo`=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Ignored requests while busy:**
  - A second `start` with a different op at cycle 10 of a run is ignored; the original result is delivered at E33.
  - `mthi` while busy leaves HI unchanged.
  - In IDLE, `mthi` with a=0x1234 gives `hi`=0x1234 next cycle.
- **Reset mid-operation:** pull `rst` low at cycle 15 of a DIV → `busy`, `done`, `hi`, `lo` all 0 immediately. After release, a fresh MULTU 7×6 gives `lo`=42, `hi`=0.
